writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage that produces the register-file write port (write_enable/write_reg_addr/write_data).
//  Merges the in-order pipeline result (ALU or load) with results from a long-latency unit (LLU, mul/div).
//  Aligns and extends load data, drops writes to x0, and gives the LLU starvation-free access via a stall request.
// PARAMETERS
//  XLEN          32  datapath width
//  REG_ADDR_W    5   register address width
//  STARVE_LIMIT  4   blocked LLU cycles before a forced pipeline stall (>=1)
// PORTS
//  clk             in   1           clock, rising edge
//  reset           in   1           asynchronous, active-low reset
//  pipe_valid      in   1           pipeline result valid this cycle (cannot be back-pressured except via stall_req)
//  pipe_rd         in   REG_ADDR_W  destination register
//  pipe_result     in   XLEN        ALU result, or raw 32-bit load word
//  pipe_is_load    in   1           pipe_result is a load word needing alignment
//  pipe_funct3     in   3           load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  pipe_addr_lo    in   2           load address bits [1:0]
//  llu_valid       in   1           LLU result valid; held with stable rd/data until accepted
//  llu_rd          in   REG_ADDR_W  LLU destination register
//  llu_data        in   XLEN        LLU result
//  llu_ready       out  1           LLU result accepted this cycle when llu_valid && llu_ready
//  stall_req       out  1           pipeline must freeze and present pipe_valid=0
//  write_enable    out  1           register-file write strobe (registered)
//  write_reg_addr  out  REG_ADDR_W  register-file write address (registered)
//  write_data      out  XLEN        register-file write data (registered)
//  load_err        out  1           one-cycle pulse: misaligned or illegal load dropped
// BEHAVIOUR
//  Reset: all outputs 0 except llu_ready (combinational, see below); state NORMAL; starve counter 0.
//  Latency: accepted result appears on write_* on the next rising edge. write_enable is high for exactly one cycle per accepted result.
//  FSM states:
//   NORMAL: llu_ready = !pipe_valid; stall_req = 0. Pipe wins on collision.
//   FORCE: llu_ready = 1; stall_req = 1. LLU wins and pipe_valid is ignored. pipe_valid=1 here is a protocol violation that the bench asserts on.
//  Starve counter ($clog2(STARVE_LIMIT+1) bits):
//   - Increments each NORMAL cycle with llu_valid && !llu_ready.
//   - Clears on any LLU handshake or when llu_valid=0.
//   - Blocked with counter == STARVE_LIMIT-1 -> next state FORCE.
//  FORCE -> NORMAL: on the LLU handshake cycle, or immediately if llu_valid drops (violation); counter cleared.
//  Load alignment (pipe_is_load=1):
//   - Byte lane = pipe_addr_lo*8; half lane = pipe_addr_lo[1]*16.
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//   - LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3 in {011,110,111}: write dropped, load_err pulsed.
//  Non-load pipe results pass through unchanged.
//  rd==0 from either source: write_enable=0, result still consumed (handshake completes), no error.
//  No accepted source: write_enable=0; write_reg_addr/write_data hold their previous values.
//  Reset asserted mid-FORCE: state NORMAL, outputs 0 asynchronously; a pending LLU result is re-offered by the LLU after reset.
// STRUCTURE
//  Shared package wb_pkg:
//   - localparams for the LB/LH/LW/LBU/LHU funct3 codes.
//   - typedef enum logic {WB_NORMAL, WB_FORCE} wb_state_t.
//  Sub-module load_aligner (combinational): data, funct3, addr_lo -> aligned data, err.
//  Remainder: FSM, starve counter, source mux, output registers.
// TESTING
//  1. pipe LB rd=5 data=0x0000_80FF addr_lo=1 -> next cycle we=1 addr=5 data=0xFFFF_FF80.
//  2. pipe LHU rd=7 data=0xABCD_1234 addr_lo=2 -> data=0x0000_ABCD; same with addr_lo=1 -> we=0, load_err=1 for 1 cycle.
//  3. pipe ALU rd=0 data=0x1234 -> we=0, no load_err; LLU rd=0 -> handshake completes, we=0.
//  4. pipe_valid and llu_valid both high one cycle, then pipe idle -> pipe written first, LLU written the next cycle with llu_ready=1.
//  5. STARVE_LIMIT=4, pipe_valid=1 continuously, llu_valid=1 rd=9 data=0xDEAD_BEEF -> after 4 blocked cycles stall_req=1, llu_ready=1; reg 9 written next edge; stall_req drops after.
//  6. reset pulsed low while in FORCE -> stall_req, we, load_err=0 immediately; NORMAL on release.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes and FSM state type.
package wb_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {WB_NORMAL, WB_FORCE} wb_state_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Bus bundle for the writeback stage: pipeline result, LLU handshake and register-file write port.
interface writeback_unit_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  pipe_valid;
   logic [REG_ADDR_W-1:0] pipe_rd;
   logic [XLEN-1:0]       pipe_result;
   logic                  pipe_is_load;
   logic [2:0]            pipe_funct3;
   logic [1:0]            pipe_addr_lo;
   logic                  llu_valid;
   logic [REG_ADDR_W-1:0] llu_rd;
   logic [XLEN-1:0]       llu_data;
   logic                  llu_ready;
   logic                  stall_req;
   logic                  write_enable;
   logic [REG_ADDR_W-1:0] write_reg_addr;
   logic [XLEN-1:0]       write_data;
   logic                  load_err;

   modport slave (
      input  pipe_valid, pipe_rd, pipe_result, pipe_is_load, pipe_funct3, pipe_addr_lo,
      input  llu_valid, llu_rd, llu_data,
      output llu_ready, stall_req, write_enable, write_reg_addr, write_data, load_err
   );

   modport master (
      output pipe_valid, pipe_rd, pipe_result, pipe_is_load, pipe_funct3, pipe_addr_lo,
      output llu_valid, llu_rd, llu_data,
      input  llu_ready, stall_req, write_enable, write_reg_addr, write_data, load_err
   );
endinterface

// File: rtl/writeback_unit_load_aligner.sv
// Combinational load-data aligner: selects byte/half lane, extends, and flags misaligned or illegal loads.
module load_aligner
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   output logic [XLEN-1:0] aligned,
   output logic            err
);

   logic [4:0]  byte_sh;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_sh = {addr_lo, 3'b000};
   assign byte_v  = data[byte_sh +: 8];
   assign half_v  = addr_lo[1] ? data[31:16] : data[15:0];

   always_comb begin
      aligned = '0;
      err     = 1'b0;
      case (funct3)
         F3_LB:  aligned = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LBU: aligned = {{(XLEN-8){1'b0}}, byte_v};
         F3_LH: begin
            aligned = {{(XLEN-16){half_v[15]}}, half_v};
            err     = addr_lo[0];
         end
         F3_LHU: begin
            aligned = {{(XLEN-16){1'b0}}, half_v};
            err     = addr_lo[0];
         end
         F3_LW: begin
            aligned = data;
            err     = (addr_lo != 2'b00);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges pipeline and LLU results onto the register-file write port,
// forcing a pipeline stall when the LLU has been blocked for STARVE_LIMIT cycles.
//
// state     | meaning
// WB_NORMAL | pipeline has priority; LLU accepted only on idle pipe cycles
// WB_FORCE  | pipeline frozen (stall_req=1); LLU result accepted unconditionally
module writeback_unit
   import wb_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   writeback_unit_if.slave    bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

   wb_state_t             state;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]       data_q;
   logic                  load_err_q;

   logic [XLEN-1:0]       aligned;
   logic                  align_err;
   logic                  llu_ready;
   logic                  pipe_take;
   logic                  llu_take;
   logic [XLEN-1:0]       pipe_data;
   logic                  pipe_err;

   load_aligner #(.XLEN(XLEN)) u_aligner (
      .data    (bus.pipe_result),
      .funct3  (bus.pipe_funct3),
      .addr_lo (bus.pipe_addr_lo),
      .aligned (aligned),
      .err     (align_err)
   );

   assign llu_ready = (state == WB_FORCE) || !bus.pipe_valid;
   assign pipe_take = (state == WB_NORMAL) && bus.pipe_valid;
   assign llu_take  = bus.llu_valid && llu_ready;
   assign pipe_data = bus.pipe_is_load ? aligned : bus.pipe_result;
   assign pipe_err  = bus.pipe_is_load && align_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= WB_NORMAL;
         starve_cnt <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         load_err_q <= 1'b0;
      end else begin
         we_q       <= 1'b0;
         load_err_q <= 1'b0;
         // x0 writes are consumed but never strobed; addr/data only move on a real write
         if (pipe_take) begin
            if (pipe_err) begin
               load_err_q <= 1'b1;
            end else if (bus.pipe_rd != '0) begin
               we_q   <= 1'b1;
               addr_q <= bus.pipe_rd;
               data_q <= pipe_data;
            end
         end else if (llu_take && (bus.llu_rd != '0)) begin
            we_q   <= 1'b1;
            addr_q <= bus.llu_rd;
            data_q <= bus.llu_data;
         end

         case (state)
            WB_NORMAL: begin
               if (bus.llu_valid && !llu_ready) begin
                  starve_cnt <= starve_cnt + 1'b1;
                  if (starve_cnt == CNT_LAST) state <= WB_FORCE;
               end else begin
                  starve_cnt <= '0;
               end
            end
            WB_FORCE: begin
               state      <= WB_NORMAL;
               starve_cnt <= '0;
            end
            default: begin
               state      <= WB_NORMAL;
               starve_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.llu_ready      = llu_ready;
   assign bus.stall_req      = (state == WB_FORCE);
   assign bus.write_enable   = we_q;
   assign bus.write_reg_addr = addr_q;
   assign bus.write_data     = data_q;
   assign bus.load_err       = load_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_writeback_unit;

   localparam int STARVE_LIMIT = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   writeback_unit_if bus ();

   writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset === 1'b1 && bus.stall_req === 1'b1)
         assert (bus.pipe_valid === 1'b0) else $error("FAIL protocol: pipe_valid=1 while stall_req=1");
   end

   task automatic drive_idle();
      bus.pipe_valid   = 1'b0;
      bus.pipe_rd      = '0;
      bus.pipe_result  = '0;
      bus.pipe_is_load = 1'b0;
      bus.pipe_funct3  = 3'b000;
      bus.pipe_addr_lo = 2'b00;
      bus.llu_valid    = 1'b0;
      bus.llu_rd       = '0;
      bus.llu_data     = '0;
   endtask

   task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] res, input logic is_load,
                             input logic [2:0] f3, input logic [1:0] alo);
      bus.pipe_valid   = 1'b1;
      bus.pipe_rd      = rd;
      bus.pipe_result  = res;
      bus.pipe_is_load = is_load;
      bus.pipe_funct3  = f3;
      bus.pipe_addr_lo = alo;
   endtask

   // Reference load semantics written from the ISA rules with plain arithmetic.
   function automatic void ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a,
                                    output logic [31:0] v, output bit err);
      int unsigned b;
      int unsigned h;
      b   = (w >> (int'(a) * 8)) & 32'hFF;
      h   = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
      v   = '0;
      err = 1'b0;
      case (f3)
         3'd0: v = (b >= 128) ? (b + 32'hFFFF_FF00) : b;
         3'd4: v = b;
         3'd1: if (a[0]) err = 1'b1; else v = (h >= 32768) ? (h + 32'hFFFF_0000) : h;
         3'd5: if (a[0]) err = 1'b1; else v = h;
         3'd2: if (a != 0) err = 1'b1; else v = w;
         default: err = 1'b1;
      endcase
   endfunction

   task automatic test_reset();
      drive_idle();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.write_enable); end
      n_checks++; if (bus.write_reg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", bus.write_reg_addr); end
      n_checks++; if (bus.write_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.write_data); end
      n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err got=%b exp=0", bus.load_err); end
      n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
      n_checks++; if (bus.llu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_llu_ready got=%b exp=1", bus.llu_ready); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_load_align();
      @(negedge clk);
      drive_pipe(5'd5, 32'h0000_80FF, 1'b1, 3'b000, 2'd1);
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'd5 || bus.write_data !== 32'hFFFF_FF80) begin
         n_fail++; $display("FAIL lb_sext got we=%b addr=%0d data=%h exp we=1 addr=5 data=ffffff80", bus.write_enable, bus.write_reg_addr, bus.write_data); end
      @(negedge clk);
      drive_pipe(5'd7, 32'hABCD_1234, 1'b1, 3'b101, 2'd2);
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'd7 || bus.write_data !== 32'h0000_ABCD) begin
         n_fail++; $display("FAIL lhu_hi got we=%b addr=%0d data=%h exp we=1 addr=7 data=0000abcd", bus.write_enable, bus.write_reg_addr, bus.write_data); end
      @(negedge clk);
      drive_pipe(5'd7, 32'hABCD_1234, 1'b1, 3'b101, 2'd1);
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b0 || bus.load_err !== 1'b1) begin
         n_fail++; $display("FAIL lhu_misaligned got we=%b err=%b exp we=0 err=1", bus.write_enable, bus.load_err); end
      @(negedge clk);
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL load_err_pulse got=%b exp=0", bus.load_err); end
      @(negedge clk);
      drive_pipe(5'd3, 32'h1234_5678, 1'b1, 3'b110, 2'd0);
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b0 || bus.load_err !== 1'b1) begin
         n_fail++; $display("FAIL illegal_f3 got we=%b err=%b exp we=0 err=1", bus.write_enable, bus.load_err); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_x0();
      @(negedge clk);
      drive_pipe(5'd0, 32'h0000_1234, 1'b0, 3'b000, 2'd0);
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b0 || bus.load_err !== 1'b0) begin
         n_fail++; $display("FAIL pipe_x0 got we=%b err=%b exp we=0 err=0", bus.write_enable, bus.load_err); end
      @(negedge clk);
      drive_idle();
      bus.llu_valid = 1'b1; bus.llu_rd = 5'd0; bus.llu_data = 32'hCAFE_0000;
      #1;
      n_checks++; if (bus.llu_ready !== 1'b1) begin n_fail++; $display("FAIL llu_x0_ready got=%b exp=1", bus.llu_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL llu_x0_we got=%b exp=0", bus.write_enable); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_collision();
      @(negedge clk);
      drive_pipe(5'd3, 32'h0000_0011, 1'b0, 3'b000, 2'd0);
      bus.llu_valid = 1'b1; bus.llu_rd = 5'd4; bus.llu_data = 32'h0000_0022;
      #1;
      n_checks++; if (bus.llu_ready !== 1'b0) begin n_fail++; $display("FAIL collide_ready got=%b exp=0", bus.llu_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'd3 || bus.write_data !== 32'h11) begin
         n_fail++; $display("FAIL collide_pipe got we=%b addr=%0d data=%h exp we=1 addr=3 data=11", bus.write_enable, bus.write_reg_addr, bus.write_data); end
      @(negedge clk);
      bus.pipe_valid = 1'b0;
      #1;
      n_checks++; if (bus.llu_ready !== 1'b1) begin n_fail++; $display("FAIL collide_llu_ready got=%b exp=1", bus.llu_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'd4 || bus.write_data !== 32'h22) begin
         n_fail++; $display("FAIL collide_llu got we=%b addr=%0d data=%h exp we=1 addr=4 data=22", bus.write_enable, bus.write_reg_addr, bus.write_data); end
      @(negedge clk);
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL single_cycle_we got=%b exp=0", bus.write_enable); end
   endtask

   task automatic starve_to_force();
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         @(negedge clk);
         drive_pipe(5'(10 + i), 32'(i + 100), 1'b0, 3'b000, 2'd0);
         bus.llu_valid = 1'b1; bus.llu_rd = 5'd9; bus.llu_data = 32'hDEAD_BEEF;
         #1;
         n_checks++; if (bus.llu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_ready[%0d] got=%b exp=0", i, bus.llu_ready); end
         @(posedge clk); #1;
         n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'(10 + i)) begin
            n_fail++; $display("FAIL starve_pipe_wr[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, bus.write_enable, bus.write_reg_addr, 10 + i); end
         n_checks++; if (bus.stall_req !== (i == STARVE_LIMIT - 1)) begin
            n_fail++; $display("FAIL starve_stall[%0d] got=%b exp=%b", i, bus.stall_req, (i == STARVE_LIMIT - 1)); end
      end
   endtask

   task automatic test_starve();
      starve_to_force();
      @(negedge clk);
      bus.pipe_valid = 1'b0;
      #1;
      n_checks++; if (bus.llu_ready !== 1'b1) begin n_fail++; $display("FAIL force_ready got=%b exp=1", bus.llu_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'd9 || bus.write_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL force_llu_wr got we=%b addr=%0d data=%h exp we=1 addr=9 data=deadbeef", bus.write_enable, bus.write_reg_addr, bus.write_data); end
      n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL force_exit got=%b exp=0", bus.stall_req); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_reset_force();
      starve_to_force();
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (bus.stall_req !== 1'b0 || bus.write_enable !== 1'b0 || bus.load_err !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got stall=%b we=%b err=%b exp all 0", bus.stall_req, bus.write_enable, bus.load_err); end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bus.stall_req !== 1'b0 || bus.llu_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset got stall=%b ready=%b exp stall=0 ready=1", bus.stall_req, bus.llu_ready); end
      @(negedge clk);
      bus.llu_valid = 1'b1; bus.llu_rd = 5'd9; bus.llu_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      n_checks++; if (bus.write_enable !== 1'b1 || bus.write_reg_addr !== 5'd9 || bus.write_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL reoffer got we=%b addr=%0d data=%h exp we=1 addr=9 data=deadbeef", bus.write_enable, bus.write_reg_addr, bus.write_data); end
      @(negedge clk);
      drive_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit          m_forced;
      int          m_blocked;
      bit          pend;
      logic [4:0]  pend_rd;
      logic [31:0] pend_data;
      bit          exp_ready;
      bit          exp_we;
      bit          exp_err;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      logic [31:0] lv;
      bit          lerr;
      m_forced  = 1'b0;
      m_blocked = 0;
      pend      = 1'b0;
      pend_rd   = '0;
      pend_data = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!pend && ($urandom_range(0, 2) == 0)) begin
            pend      = 1'b1;
            pend_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pend_data = $urandom;
         end
         bus.llu_valid = pend;
         bus.llu_rd    = pend_rd;
         bus.llu_data  = pend_data;
         if (!m_forced && ($urandom_range(0, 3) != 0))
            drive_pipe(($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         else
            bus.pipe_valid = 1'b0;

         exp_ready = m_forced || !bus.pipe_valid;
         exp_we    = 1'b0;
         exp_err   = 1'b0;
         exp_addr  = '0;
         exp_data  = '0;
         if (bus.pipe_valid) begin
            if (bus.pipe_is_load) ref_load(bus.pipe_result, bus.pipe_funct3, bus.pipe_addr_lo, lv, lerr);
            else begin lv = bus.pipe_result; lerr = 1'b0; end
            exp_err  = lerr;
            exp_we   = !lerr && (bus.pipe_rd != 0);
            exp_addr = bus.pipe_rd;
            exp_data = lv;
         end else if (pend) begin
            exp_we   = (pend_rd != 0);
            exp_addr = pend_rd;
            exp_data = pend_data;
         end
         // starvation bookkeeping: count consecutive blocked cycles, force on the limit-th
         if (m_forced) begin
            m_forced  = 1'b0;
            m_blocked = 0;
         end else if (pend && !exp_ready) begin
            m_blocked = m_blocked + 1;
            if (m_blocked == STARVE_LIMIT) m_forced = 1'b1;
         end else begin
            m_blocked = 0;
         end

         #1;
         n_checks++; if (bus.llu_ready !== exp_ready) begin
            n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.llu_ready, exp_ready); end
         if (pend && exp_ready) pend = 1'b0;
         @(posedge clk); #1;
         n_checks++; if (bus.write_enable !== exp_we || bus.load_err !== exp_err || bus.stall_req !== m_forced) begin
            n_fail++; $display("FAIL rnd_ctrl cyc=%0d got we=%b err=%b stall=%b exp we=%b err=%b stall=%b",
                               cyc, bus.write_enable, bus.load_err, bus.stall_req, exp_we, exp_err, m_forced); end
         if (exp_we) begin
            n_checks++; if (bus.write_reg_addr !== exp_addr || bus.write_data !== exp_data) begin
               n_fail++; $display("FAIL rnd_write cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                                  cyc, bus.write_reg_addr, bus.write_data, exp_addr, exp_data); end
         end
      end
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      drive_idle();
      test_reset();
      test_load_align();
      test_x0();
      test_collision();
      test_starve();
      test_reset_force();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
